multi_cond_sequencer: RTL and testbench
=======================================

Name: multi_cond_sequencer

Overview:
- Parametrised N-channel successor to the two-condition arrival tracker and acknowledge controller.
- Records which condition inputs have been seen (sticky), which channel arrived first and which arrived last.
- Drives an arm-gated controller with active/done/error outputs and a completion timeout.
- Sits behind the io_in/io_out top wrapper; cond, arm and clear come from io_in; state and status go to io_out.

Parameters:
- N_CH, 4, number of condition channels (2..8).
- TIMEOUT_CYC, 16, max cycles in TRACK before ERR; 0 disables the timeout.
- CNT_W, 8, timeout counter width; TIMEOUT_CYC must be < 2**CNT_W.
- IDX_W (localparam), max(1, clog2(N_CH)), channel index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cond  in  N_CH  condition inputs, level-sampled each clk.
- arm  in  1  enable for the controller (IDLE exit qualifier).
- clear  in  1  synchronous clear back to the reset state.
- seen  out  N_CH  sticky per-channel seen flags.
- first_idx  out  IDX_W  index of the first-arriving channel.
- last_idx  out  IDX_W  index of the channel that completed the set.
- state  out  2  controller state: 00 IDLE, 01 TRACK, 10 DONE, 11 ERR.
- active  out  1  high only in TRACK.
- done  out  1  one-cycle pulse on entry to DONE.
- err  out  1  high while in ERR.

Behaviour:
- Reset (rst_n low, async) forces all outputs and internal registers to 0 and state to IDLE.
- Priority per edge is clear > completion > timeout > normal.
- clear=1: next edge gives the same values as reset; cond is ignored that cycle.
- Tracker (independent of arm), for every edge with clear=0:
  - seen <= seen | cond.
  - When seen==0 and cond!=0: first_idx <= lowest set index of cond.
  - When seen!=all-ones and (seen|cond)==all-ones: last_idx <= highest index in (cond & ~seen).
  - A channel already seen has no further effect; deasserting cond never clears seen.
- Controller, state by state:
  - IDLE: if arm=1 and next seen is all-ones, go to DONE. If arm=1 and next seen is non-zero, go to TRACK and clear the timer. Otherwise stay. With arm=0, seen still accumulates but the state stays IDLE.
  - TRACK: the timer increments each cycle. When next seen is all-ones, go to DONE; this wins over a timeout in the same cycle. When TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1, go to ERR. arm is ignored in TRACK.
  - DONE: holds until clear.
  - ERR: holds until clear. seen keeps accumulating; first_idx and last_idx keep updating per the tracker rules.
- Output timing:
  - All outputs are registered or decoded from registered state.
  - active, err and state change on the edge after the qualifying inputs are sampled.
  - done is high for exactly the first cycle state==DONE.
- Timing and width rules:
  - Latency from a cond sample to the seen update is 1 cycle.
  - The timer saturates and never wraps.
  - With N_CH=2 the block behaves like the original two-condition controller, with Ca = {state==DONE|ERR ? ... } replaced by the state output.

Optional Feature:
- Macro: MCS_ORDER_CHECK_EN.
- When defined, arrivals must be in ascending channel order. Going to ERR is triggered if a newly set channel i has some j>i already in seen; this applies in IDLE with arm=1 or in TRACK. Simultaneous new arrivals are legal; they are treated as ascending by index.
- When not defined, any arrival order is accepted and no order logic is synthesised.

Test Plan:
- Reset and idle: assert rst_n=0 mid-TRACK, asynchronously -> state=00, seen=0, active=0, done=0, err=0 immediately; hold rst_n=1, arm=0, cond=0 -> outputs stay 0.
- N_CH=4, arm=1, cond=0010 then 1000 then 0001 then 0100 on consecutive cycles -> TRACK after the first edge, first_idx=1, last_idx=2, DONE on the 4th edge, done high 1 cycle, active low in DONE.
- arm=0 with cond=1111 for 1 cycle, then arm=1 -> seen=1111 while IDLE, then DONE on the arm edge; first_idx=0, last_idx=3.
- TIMEOUT_CYC=16: arm=1, cond=0001 only -> ERR exactly 16 cycles after TRACK entry, err=1; completing on cycle 16 instead -> DONE, err=0.
- clear=1 while in DONE with cond=1111 held -> next cycle IDLE, seen=0000, then re-accumulates 1111 on the following edge.
- MCS_ORDER_CHECK_EN defined: cond=0100 then 0010 with arm=1 -> ERR; cond=0011 together then 1100 -> DONE, no error.

Source files
------------

// File: rtl/multi_cond_sequencer.sv
// N-channel condition sequencer: sticky seen flags, first/last arrival index, arm-gated controller with timeout.
// Optional ascending-order arrival checking is enabled by defining MCS_ORDER_CHECK_EN.
module multi_cond_sequencer #(
    parameter int N_CH        = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8,
    localparam int IDX_W      = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  cond,
    input  logic             arm,
    input  logic             clear,
    output logic [N_CH-1:0]  seen,
    output logic [IDX_W-1:0] first_idx,
    output logic [IDX_W-1:0] last_idx,
    output logic [1:0]       state,
    output logic             active,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERR   = 2'b11
    } state_t;

    localparam logic [N_CH-1:0]  ALL_ONES = {N_CH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYC > 32'sd0) ? (TIMEOUT_CYC - 32'sd1) : 32'sd0);
    localparam logic             TO_EN    = (TIMEOUT_CYC > 32'sd0);

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
        lowest_idx = {IDX_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            lowest_idx = v[i] ? IDX_W'(i) : lowest_idx;
        end
    endfunction

    function automatic logic [IDX_W-1:0] highest_idx(input logic [N_CH-1:0] v);
        highest_idx = {IDX_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            highest_idx = v[i] ? IDX_W'(i) : highest_idx;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [N_CH-1:0]  seen_r;
    logic [IDX_W-1:0] first_idx_r;
    logic [IDX_W-1:0] last_idx_r;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_nxt_s;
    logic             done_r;
    logic [N_CH-1:0]  seen_nxt_s;
    logic [N_CH-1:0]  new_s;
    logic             complete_s;
    logic             timeout_s;
    logic             order_viol_s;
    logic             active_s;
    logic             err_s;

    assign seen_nxt_s = seen_r | cond;
    assign new_s      = cond & ~seen_r;
    assign complete_s = (seen_nxt_s == ALL_ONES);
    assign timeout_s  = TO_EN && (timer_r == TO_LAST);

`ifdef MCS_ORDER_CHECK_EN
    logic [N_CH-1:0] above_s;

    // A new arrival is out of order when any higher channel has already been seen.
    always_comb begin
        above_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            for (int j = i + 1; j < N_CH; j++) begin
                above_s[i] = above_s[i] | seen_r[j];
            end
        end
        order_viol_s = |(new_s & above_s);
    end
`else
    assign order_viol_s = 1'b0;
`endif

    // Arrival tracker: runs regardless of arm or controller state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_r      <= {N_CH{1'b0}};
            first_idx_r <= {IDX_W{1'b0}};
            last_idx_r  <= {IDX_W{1'b0}};
        end else if (clear) begin
            seen_r      <= {N_CH{1'b0}};
            first_idx_r <= {IDX_W{1'b0}};
            last_idx_r  <= {IDX_W{1'b0}};
        end else begin
            seen_r <= seen_nxt_s;
            if ((seen_r == {N_CH{1'b0}}) && (cond != {N_CH{1'b0}})) begin
                first_idx_r <= lowest_idx(cond);
            end
            if ((seen_r != ALL_ONES) && complete_s) begin
                last_idx_r <= highest_idx(new_s);
            end
        end
    end

    // Controller state, timer and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else if (clear) begin
            state_r <= ST_IDLE;
            timer_r <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
        end
    end

    // Next-state logic; completion outranks timeout and order errors.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!arm) begin
                    state_nxt_s = ST_IDLE;
                end else if (complete_s) begin
                    state_nxt_s = ST_DONE;
                end else if (order_viol_s) begin
                    state_nxt_s = ST_ERR;
                end else if (seen_nxt_s != {N_CH{1'b0}}) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (complete_s) begin
                    state_nxt_s = ST_DONE;
                end else if (timeout_s || order_viol_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_TRACK;
                end
            end
            ST_DONE: state_nxt_s = ST_DONE;
            ST_ERR:  state_nxt_s = ST_ERR;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Timer counts only while tracking and saturates instead of wrapping.
    always_comb begin
        timer_nxt_s = {CNT_W{1'b0}};
        if (state_r != ST_TRACK) begin
            timer_nxt_s = {CNT_W{1'b0}};
        end else if (timer_r == CNT_MAX) begin
            timer_nxt_s = timer_r;
        end else begin
            timer_nxt_s = timer_r + CNT_W'(1);
        end
    end

    // Status decode from the registered state.
    always_comb begin
        active_s = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_TRACK: active_s = 1'b1;
            ST_ERR:   err_s    = 1'b1;
            default: begin
                active_s = 1'b0;
                err_s    = 1'b0;
            end
        endcase
    end

    assign seen      = seen_r;
    assign first_idx = first_idx_r;
    assign last_idx  = last_idx_r;
    assign state     = state_r;
    assign active    = active_s;
    assign done      = done_r;
    assign err       = err_s;

endmodule

// File: tb/tb_multi_cond_sequencer.sv
// Directed bench for multi_cond_sequencer (N_CH=4, TIMEOUT_CYC=16); order-check scenario follows MCS_ORDER_CHECK_EN.
module tb_multi_cond_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cond = 4'b0000;
    logic       arm = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] seen;
    logic [1:0] first_idx;
    logic [1:0] last_idx;
    logic [1:0] state;
    logic       active;
    logic       done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;
    logic [12:0] obs;
    logic [12:0] exp_v;

    multi_cond_sequencer #(.N_CH(4), .TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cond(cond), .arm(arm), .clear(clear),
        .seen(seen), .first_idx(first_idx), .last_idx(last_idx),
        .state(state), .active(active), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // obs = {state, seen, first_idx, last_idx, active, done, err}
    assign obs = {state, seen, first_idx, last_idx, active, done, err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; arm = 1'b0; cond = 4'b0000;
        tick();
        clear = 1'b0;
        exp_v = {2'b00, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL clear_state got %h exp %h", obs, exp_v); n_err++; end
    endtask

    task automatic test_reset();
        arm = 1'b1; cond = 4'b0001;
        tick();
        exp_v = {2'b01, 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL reset_pre_track got %h exp %h", obs, exp_v); n_err++; end
        rst_n = 1'b0;
        #1;
        exp_v = 13'd0;
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL async_reset got %h exp %h", obs, exp_v); n_err++; end
        #2;
        rst_n = 1'b1; arm = 1'b0; cond = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (obs !== 13'd0) begin $display("FAIL idle_hold[%0d] got %h exp %h", k, obs, 13'd0); n_err++; end
        end
    endtask

    task automatic test_sequence();
        logic [3:0]  seq_c [4];
        logic [12:0] seq_e [5];
        seq_c[0] = 4'b0010; seq_c[1] = 4'b1000; seq_c[2] = 4'b0001; seq_c[3] = 4'b0100;
        seq_e[0] = {2'b01, 4'b0010, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0};
        seq_e[1] = {2'b01, 4'b1010, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0};
        seq_e[2] = {2'b01, 4'b1011, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0};
        seq_e[3] = {2'b10, 4'b1111, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0};
        seq_e[4] = {2'b10, 4'b1111, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
        do_clear();
        arm = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cond = (k < 4) ? seq_c[k] : 4'b0000;
            tick();
            n_vec++;
            if (obs !== seq_e[k]) begin $display("FAIL sequence[%0d] got %h exp %h", k, obs, seq_e[k]); n_err++; end
        end
    endtask

    task automatic test_arm_gate();
        do_clear();
        arm = 1'b0; cond = 4'b1111;
        tick();
        exp_v = {2'b00, 4'b1111, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL arm_low_accum got %h exp %h", obs, exp_v); n_err++; end
        arm = 1'b1; cond = 4'b0000;
        tick();
        exp_v = {2'b10, 4'b1111, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL arm_edge_done got %h exp %h", obs, exp_v); n_err++; end
    endtask

    task automatic test_timeout();
        do_clear();
        arm = 1'b1; cond = 4'b0001;
        tick();
        cond = 4'b0000;
        exp_v = {2'b01, 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_vec++;
            if (obs !== exp_v) begin $display("FAIL timeout_track[%0d] got %h exp %h", k, obs, exp_v); n_err++; end
        end
        tick();
        exp_v = {2'b11, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL timeout_err got %h exp %h", obs, exp_v); n_err++; end
        cond = 4'b0100;
        tick();
        exp_v = {2'b11, 4'b0101, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL err_accum got %h exp %h", obs, exp_v); n_err++; end
        cond = 4'b1010;
        tick();
        exp_v = {2'b11, 4'b1111, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL err_last_idx got %h exp %h", obs, exp_v); n_err++; end
    endtask

    task automatic test_complete_at_limit();
        do_clear();
        arm = 1'b1; cond = 4'b0001;
        tick();
        cond = 4'b0000;
        for (int k = 1; k <= 15; k++) tick();
        cond = 4'b1110;
        tick();
        exp_v = {2'b10, 4'b1111, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL done_beats_timeout got %h exp %h", obs, exp_v); n_err++; end
    endtask

    task automatic test_back_to_back();
        do_clear();
        arm = 1'b1; cond = 4'b1111;
        tick();
        exp_v = {2'b10, 4'b1111, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL direct_done got %h exp %h", obs, exp_v); n_err++; end
        clear = 1'b1;
        tick();
        n_vec++;
        if (obs !== 13'd0) begin $display("FAIL clear_in_done got %h exp %h", obs, 13'd0); n_err++; end
        clear = 1'b0; arm = 1'b0;
        tick();
        exp_v = {2'b00, 4'b1111, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL reaccum got %h exp %h", obs, exp_v); n_err++; end
    endtask

    task automatic test_order();
        do_clear();
        arm = 1'b1; cond = 4'b0100;
        tick();
        exp_v = {2'b01, 4'b0100, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL order_first got %h exp %h", obs, exp_v); n_err++; end
        cond = 4'b0010;
        tick();
`ifdef MCS_ORDER_CHECK_EN
        exp_v = {2'b11, 4'b0110, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1};
`else
        exp_v = {2'b01, 4'b0110, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0};
`endif
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL order_descend got %h exp %h", obs, exp_v); n_err++; end
        do_clear();
        arm = 1'b1; cond = 4'b0011;
        tick();
        exp_v = {2'b01, 4'b0011, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL order_pair got %h exp %h", obs, exp_v); n_err++; end
        cond = 4'b1100;
        tick();
        exp_v = {2'b10, 4'b1111, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL order_ascend_done got %h exp %h", obs, exp_v); n_err++; end
    endtask

    initial begin
        #12;
        n_vec++;
        if (obs !== 13'd0) begin $display("FAIL reset_values got %h exp %h", obs, 13'd0); n_err++; end
        rst_n = 1'b1;
        test_reset();
        test_sequence();
        test_arm_gate();
        test_timeout();
        test_complete_at_limit();
        test_back_to_back();
        test_order();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
